retire_trace_serializer: RTL and testbench
==========================================

# retire_trace_serializer

Receiving end of the core's dual-slot retirement trace interface. Accepts up to two retired-instruction records per cycle (slot 0 older than slot 1), buffers them in a small FIFO, and presents them one per cycle, in program order, on a valid/ready stream for the table logger and grading monitor. The retire interface has no backpressure; the block detects and flags lost records rather than stalling the core.

## Interface

Parameters:

- IssueWidth, 2, number of retire slots; this block supports exactly 2.
- Depth, 8, FIFO entries; power of two, ≥ 2.

Ports:

- clk_i  input  1  system clock
- rst_i  input  1  reset; asynchronous, active-high
- update_i  input  1 [IssueWidth]  slot retire strobe
- pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i  input  XLEN [IssueWidth]  retired fields per slot
- reg_addr_i  input  5 [IssueWidth]  retired rd
- mem_wrt_i  input  1 [IssueWidth]  retired store flag
- rec_valid_o  output  1  head record valid
- rec_ready_i  input  1  consumer accepts head
- rec_o  output  trace_rec_t  head record
- rec_seq_o  output  32  retire sequence number of head record
- overflow_o  output  1  sticky; at least one record dropped
- drop_cnt_o  output  16  dropped-record count, saturating

## Operation

- Each cycle, collect the valid slots in order: slot 0, then slot 1. Slot 1 valid with slot 0 idle enqueues slot 1 alone.
- free = Depth − count + pop, where pop = rec_valid_o & rec_ready_i. Same-cycle pop frees a slot for push.
- Enqueue incoming records in order while free > 0. Drop the remainder: slot 1 is dropped before slot 0. For each drop, set overflow_o and increment drop_cnt_o, saturating at 0xFFFF.
- Sequence counter seq (32 bit) advances by the number of valid slots, counting dropped records too. Each record stores seq + its in-cycle index (0 or 1), so gaps in rec_seq_o expose drops. The counter wraps modulo 2^32.
- Stream rule: rec_o and rec_seq_o hold stable while rec_valid_o & !rec_ready_i. The consumer may hold rec_ready_i high continuously.
- rec_valid_o = (count != 0). With rec_ready_i high and no new input, the FIFO drains at one record per cycle.
- Read and write pointers are log2(Depth) bits and wrap naturally. count is log2(Depth)+1 bits, range 0..Depth.

## Timing

- Reset values: count, pointers, seq, drop_cnt_o = 0; overflow_o = 0; rec_valid_o = 0; rec_o = '0; rec_seq_o = 0.
- Latency: a record presented with update_i at edge N appears on rec_o after edge N, when the FIFO was empty.
- Throughput: one record out per cycle. Sustained two retires per cycle overflows after about Depth cycles if the consumer does not keep up.
- Full with pop asserted: the push of 1 record proceeds in the same cycle, with no drop.
- Reset mid-operation: the FIFO contents are discarded immediately (asynchronous). overflow_o clears only on reset.

## Structure

- riscv_pkg holds:
  - XLEN.
  - trace_rec_t, a packed struct: pc, instr, reg_addr, reg_data, mem_addr, mem_data, mem_wrt.
  - trace_seq_t, 32 bits.
- Sub-module trace_fifo: synchronous, 2-push/1-pop, parameterised on width and Depth. It reports count and accepts push count 0..2.
- The top level handles slot ordering, the free-space and drop decision, and the sequence and drop counters.

## Test plan

- Reset, then a single slot-0 retire with pc=0x80000000 and rec_ready_i=1: rec_valid_o rises one cycle later with pc=0x80000000, rec_seq_o=0. It falls the next cycle.
- Dual retire with pc 0x100/0x104 and ready held 1: outputs 0x100 (seq 0), then 0x104 (seq 1), on consecutive cycles.
- Slot 1 only, with pc=0x200: one record with pc=0x200. The next dual retire yields seq 1 and 2.
- rec_ready_i=0, then 4 dual retires with Depth=8: FIFO full, no overflow. A 5th dual retire drops both records: overflow_o=1, drop_cnt_o=2. Draining then yields seq 0..7.
- Full FIFO with ready=1 and a single retire in the same cycle: no drop, count stays 8. rec_o is stable during an earlier ready=0 hold.
- Assert rst_i mid-drain: rec_valid_o=0 immediately, overflow_o=0, and the next retire carries seq 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the retirement trace path: record layout, sequence type and FIFO entry.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef logic [31:0] trace_seq_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      reg_addr;
        logic [XLEN-1:0] reg_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
        logic            mem_wrt;
    } trace_rec_t;

    // Each buffered entry carries its own sequence number so gaps survive the FIFO.
    typedef struct packed {
        trace_seq_t seq;
        trace_rec_t rec;
    } trace_ent_t;

    function automatic logic [1:0] ones2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous 2-push/1-pop FIFO; push_cnt must never exceed the free space the caller computes.
module trace_fifo #(
    parameter int Width = 8,
    parameter int Depth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [1:0]                 push_cnt,
    input  logic [Width-1:0]           push_dat0,
    input  logic [Width-1:0]           push_dat1,
    input  logic                       pop,
    output logic [$clog2(Depth):0]     count,
    output logic [Width-1:0]           head_dat
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr_nxt1;

    assign wptr_nxt1 = wptr + AW'(1);
    assign head_dat  = mem[rptr];

    // Storage is not reset; validity is tracked by count alone.
    always_ff @(posedge clk_i) begin
        if (push_cnt != 2'd0) begin
            mem[wptr] <= push_dat0;
        end
        if (push_cnt == 2'd2) begin
            mem[wptr_nxt1] <= push_dat1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(push_cnt);
            rptr  <= rptr + AW'(pop);
            count <= count + (AW+1)'(push_cnt) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/retire_trace_serializer.sv
// Dual-slot retirement trace to single valid/ready stream; never stalls the core,
// drops and counts records when the buffer is full.
module retire_trace_serializer
    import riscv_pkg::*;
#(
    parameter int IssueWidth = 2,
    parameter int Depth      = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [IssueWidth-1:0]                update_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]      pc_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]      instr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]      reg_data_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]      mem_addr_i,
    input  logic [IssueWidth-1:0][XLEN-1:0]      mem_data_i,
    input  logic [IssueWidth-1:0][4:0]           reg_addr_i,
    input  logic [IssueWidth-1:0]                mem_wrt_i,
    output logic                                 rec_valid_o,
    input  logic                                 rec_ready_i,
    output trace_rec_t                           rec_o,
    output logic [31:0]                          rec_seq_o,
    output logic                                 overflow_o,
    output logic [15:0]                          drop_cnt_o
);

    localparam int AW = $clog2(Depth);
    localparam int EW = $bits(trace_ent_t);

    trace_rec_t        slot_rec [2];
    trace_ent_t        ent_a;
    trace_ent_t        ent_b;
    trace_ent_t        head;
    trace_seq_t        seq_q;
    logic [AW:0]       count;
    logic [AW:0]       free;
    logic              pop;
    logic [1:0]        n_valid;
    logic [1:0]        n_push;
    logic [1:0]        n_drop;
    logic [16:0]       drop_sum;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            slot_rec[k].pc       = pc_i[k];
            slot_rec[k].instr    = instr_i[k];
            slot_rec[k].reg_addr = reg_addr_i[k];
            slot_rec[k].reg_data = reg_data_i[k];
            slot_rec[k].mem_addr = mem_addr_i[k];
            slot_rec[k].mem_data = mem_data_i[k];
            slot_rec[k].mem_wrt  = mem_wrt_i[k];
        end
    end

    // Compact the valid slots: ent_a is the oldest valid record, ent_b exists only on a dual retire.
    always_comb begin
        ent_a.seq = seq_q;
        ent_a.rec = update_i[0] ? slot_rec[0] : slot_rec[1];
        ent_b.seq = seq_q + 32'd1;
        ent_b.rec = slot_rec[1];
    end

    assign rec_valid_o = (count != '0);
    assign pop         = rec_valid_o & rec_ready_i;
    assign n_valid     = ones2(update_i[1:0]);
    assign free        = (AW+1)'(Depth) - count + (AW+1)'(pop);

    // Free space below two can only be 0 or 1, so the low bits are the exact push count.
    always_comb begin
        n_push = n_valid;
        if (free < (AW+1)'(n_valid)) begin
            n_push = free[1:0];
        end
        n_drop = n_valid - n_push;
    end

    trace_fifo #(
        .Width (EW),
        .Depth (Depth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_cnt  (n_push),
        .push_dat0 (ent_a),
        .push_dat1 (ent_b),
        .pop       (pop),
        .count     (count),
        .head_dat  (head)
    );

    assign rec_o     = rec_valid_o ? head.rec : '0;
    assign rec_seq_o = rec_valid_o ? head.seq : '0;

    assign drop_sum = {1'b0, drop_cnt_o} + 17'(n_drop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seq_q      <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            seq_q <= seq_q + 32'(n_valid);
            if (n_drop != 2'd0) begin
                overflow_o <= 1'b1;
                drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_retire_trace_serializer.sv
// Directed bench: vector table for basic ordering, hand sequences for overflow, full+pop and async reset.
module tb_retire_trace_serializer;
    import riscv_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [1:0]            update = '0;
    logic [1:0][31:0]      pc = '0, instr = '0, reg_data = '0, mem_addr = '0, mem_data = '0;
    logic [1:0][4:0]       reg_addr = '0;
    logic [1:0]            mem_wrt = '0;
    logic                  rdy = 1'b0;
    logic                  valid;
    trace_rec_t            rec;
    logic [31:0]           seq;
    logic                  ovf;
    logic [15:0]           drop;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    retire_trace_serializer #(.IssueWidth(2), .Depth(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .update_i    (update),
        .pc_i        (pc),
        .instr_i     (instr),
        .reg_data_i  (reg_data),
        .mem_addr_i  (mem_addr),
        .mem_data_i  (mem_data),
        .reg_addr_i  (reg_addr),
        .mem_wrt_i   (mem_wrt),
        .rec_valid_o (valid),
        .rec_ready_i (rdy),
        .rec_o       (rec),
        .rec_seq_o   (seq),
        .overflow_o  (ovf),
        .drop_cnt_o  (drop)
    );

    typedef struct {
        bit          do_rst;
        logic [1:0]  upd;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        rdy;
        logic        exp_vld;
        logic [31:0] exp_pc;
        logic [31:0] exp_seq;
        logic        exp_ovf;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t vecs [9];

    function automatic trace_rec_t mk_rec(input logic [31:0] p);
        trace_rec_t r;
        r.pc       = p;
        r.instr    = ~p;
        r.reg_addr = p[6:2];
        r.reg_data = p + 32'h11;
        r.mem_addr = p ^ 32'hA5A5_0000;
        r.mem_data = {p[15:0], p[31:16]};
        r.mem_wrt  = p[2];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_slot(input int k, input logic [31:0] p);
        trace_rec_t r;
        r = mk_rec(p);
        pc[k]       = r.pc;
        instr[k]    = r.instr;
        reg_addr[k] = r.reg_addr;
        reg_data[k] = r.reg_data;
        mem_addr[k] = r.mem_addr;
        mem_data[k] = r.mem_data;
        mem_wrt[k]  = r.mem_wrt;
    endtask

    task automatic drive(input logic [1:0] u, input logic [31:0] p0, input logic [31:0] p1);
        update = u;
        set_slot(0, p0);
        set_slot(1, p1);
    endtask

    // Leaves the bench aligned to a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(2'b00, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic head_is(input string nm, input logic [31:0] p, input logic [31:0] s);
        chk({nm, "_vld"}, 192'(valid), 192'(1'b1));
        chk({nm, "_rec"}, 192'(rec), 192'(mk_rec(p)));
        chk({nm, "_seq"}, 192'(seq), 192'(s));
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'b01, 32'h8000_0000, 32'h0,   1'b1, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 2'b00, 32'h0,         32'h0,   1'b1, 1'b0, 32'h0,         32'd0, 1'b0, 16'd0};
        vecs[2] = '{1'b1, 2'b11, 32'h100,       32'h104, 1'b1, 1'b1, 32'h100,       32'd0, 1'b0, 16'd0};
        vecs[3] = '{1'b0, 2'b00, 32'h0,         32'h0,   1'b1, 1'b1, 32'h104,       32'd1, 1'b0, 16'd0};
        vecs[4] = '{1'b0, 2'b00, 32'h0,         32'h0,   1'b1, 1'b0, 32'h0,         32'd0, 1'b0, 16'd0};
        vecs[5] = '{1'b1, 2'b10, 32'h0,         32'h200, 1'b1, 1'b1, 32'h200,       32'd0, 1'b0, 16'd0};
        vecs[6] = '{1'b0, 2'b11, 32'h300,       32'h304, 1'b1, 1'b1, 32'h300,       32'd1, 1'b0, 16'd0};
        vecs[7] = '{1'b0, 2'b00, 32'h0,         32'h0,   1'b1, 1'b1, 32'h304,       32'd2, 1'b0, 16'd0};
        vecs[8] = '{1'b0, 2'b00, 32'h0,         32'h0,   1'b1, 1'b0, 32'h0,         32'd0, 1'b0, 16'd0};

        // Reset state
        do_reset();
        chk("rst_vld",  192'(valid), 192'(1'b0));
        chk("rst_rec",  192'(rec),   192'(0));
        chk("rst_seq",  192'(seq),   192'(0));
        chk("rst_ovf",  192'(ovf),   192'(1'b0));
        chk("rst_drop", 192'(drop),  192'(0));

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_rst) do_reset();
            rdy = vecs[i].rdy;
            drive(vecs[i].upd, vecs[i].pc0, vecs[i].pc1);
            @(negedge clk);
            chk($sformatf("v%0d_vld", i), 192'(valid), 192'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) begin
                chk($sformatf("v%0d_rec", i), 192'(rec), 192'(mk_rec(vecs[i].exp_pc)));
                chk($sformatf("v%0d_seq", i), 192'(seq), 192'(vecs[i].exp_seq));
            end
            chk($sformatf("v%0d_ovf", i),  192'(ovf),  192'(vecs[i].exp_ovf));
            chk($sformatf("v%0d_drop", i), 192'(drop), 192'(vecs[i].exp_drop));
        end
        drive(2'b00, 32'h0, 32'h0);

        // Fill with consumer stalled, overflow on the fifth dual retire, then drain
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 32'h1000 + 32'(8*i), 32'h1004 + 32'(8*i));
            @(negedge clk);
            head_is($sformatf("fill%0d", i), 32'h1000, 32'd0);
        end
        chk("fill_ovf",  192'(ovf),  192'(1'b0));
        chk("fill_drop", 192'(drop), 192'(0));
        drive(2'b11, 32'h2000, 32'h2004);
        @(negedge clk);
        chk("ovf_set",  192'(ovf),  192'(1'b1));
        chk("ovf_drop", 192'(drop), 192'(2));
        head_is("ovf_head", 32'h1000, 32'd0);
        drive(2'b00, 32'h0, 32'h0);
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            head_is($sformatf("drain%0d", i), 32'h1000 + 32'(4*i), 32'(i));
            @(negedge clk);
        end
        chk("drain_empty", 192'(valid), 192'(1'b0));
        drive(2'b01, 32'h3000, 32'h0);
        @(negedge clk);
        head_is("gap", 32'h3000, 32'd10);
        chk("gap_drop", 192'(drop), 192'(2));
        chk("gap_ovf",  192'(ovf),  192'(1'b1));
        drive(2'b00, 32'h0, 32'h0);

        // Full FIFO, pop and single push in the same cycle
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 32'h4000 + 32'(8*i), 32'h4004 + 32'(8*i));
            @(negedge clk);
        end
        rdy = 1'b1;
        drive(2'b01, 32'h5000, 32'h0);
        @(negedge clk);
        chk("fullpop_ovf",  192'(ovf),  192'(1'b0));
        chk("fullpop_drop", 192'(drop), 192'(0));
        drive(2'b00, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            head_is($sformatf("fp%0d", i), (i < 7) ? 32'h4000 + 32'(4*(i+1)) : 32'h5000, 32'(i + 1));
            @(negedge clk);
        end
        chk("fp_empty", 192'(valid), 192'(1'b0));

        // Asynchronous reset while draining an overflowed FIFO
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 32'h6000 + 32'(8*i), 32'h6004 + 32'(8*i));
            @(negedge clk);
        end
        chk("pre_rst_ovf", 192'(ovf), 192'(1'b1));
        drive(2'b00, 32'h0, 32'h0);
        rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld",  192'(valid), 192'(1'b0));
        chk("arst_ovf",  192'(ovf),   192'(1'b0));
        chk("arst_drop", 192'(drop),  192'(0));
        @(negedge clk);
        rst = 1'b0;
        drive(2'b01, 32'h7000, 32'h0);
        @(negedge clk);
        head_is("post_rst", 32'h7000, 32'd0);
        drive(2'b00, 32'h0, 32'h0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
